imem_fetch: RTL and testbench

Byte-addressed instruction memory that answers the 8-bit CPU's instruction fetches. It returns the 32-bit little-endian instruction word at the CPU's PC, after a fixed latency, and holds the CPU with BUSYWAIT until the word is valid. It also has a byte-serial loader port, used by the testbench or boot logic to fill the program before the CPU runs.

---
 rtl/imem_fetch_if.sv | 24 ++
 rtl/imem_fetch.sv | 110 +++++++++++
 tb/tb_imem_fetch.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_if.sv
// rtl/imem_fetch_if.sv - fetch and loader bus between CPU/boot side (master) and instruction memory (slave)
interface imem_fetch_if #(
  parameter int AW = 10
);
  logic [31:0]   ADDRESS;
  logic          READ;
  logic [31:0]   READDATA;
  logic          BUSYWAIT;
  logic          ILLEGAL;
  logic          LOAD_VALID;
  logic [7:0]    LOAD_BYTE;
  logic          LOAD_READY;
  logic [AW-1:0] LOAD_PTR;

  modport master (
    output ADDRESS, READ, LOAD_VALID, LOAD_BYTE,
    input  READDATA, BUSYWAIT, ILLEGAL, LOAD_READY, LOAD_PTR
  );

  modport slave (
    input  ADDRESS, READ, LOAD_VALID, LOAD_BYTE,
    output READDATA, BUSYWAIT, ILLEGAL, LOAD_READY, LOAD_PTR
  );
endinterface

// File: rtl/imem_fetch.sv
// rtl/imem_fetch.sv - byte-addressed instruction memory with fixed-latency word fetch and byte-serial loader
// Optional opcode range check on fetched words is enabled by defining IMEM_OPCODE_CHECK_EN.
module imem_fetch #(
  parameter  int DEPTH_BYTES = 1024,
  parameter  int LATENCY     = 2,
  localparam int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic        CLK,
  input  logic        RESET,
  imem_fetch_if.slave bus
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] load_ptr;
  logic [31:0]   rdata;
  logic [31:0]   word;
  logic          accept;
  logic          capture;
  logic          busy;
  logic          load_ready;
  logic          do_load;
  logic          unused_addr_bits;

  logic [7:0] mem [DEPTH_BYTES];

  assign unused_addr_bits = ^{bus.ADDRESS[31:AW], bus.ADDRESS[1:0]};

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    capture    = 1'b0;
    busy       = 1'b0;
    load_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = !bus.READ;
        if (bus.READ) begin
          accept    = 1'b1;
          busy      = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (cnt == '0) begin
          capture   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A loader byte arriving with RESET must not land in memory.
  assign do_load = bus.LOAD_VALID && load_ready && !RESET;

  assign word = {mem[{addr_q[AW-1:2], 2'd3}], mem[{addr_q[AW-1:2], 2'd2}],
                 mem[{addr_q[AW-1:2], 2'd1}], mem[{addr_q[AW-1:2], 2'd0}]};

  always_ff @(posedge CLK) begin
    if (do_load) mem[load_ptr] <= bus.LOAD_BYTE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt      <= '0;
      rdata    <= 32'h0;
      load_ptr <= '0;
    end else begin
      if (accept) begin
        addr_q <= {bus.ADDRESS[AW-1:2], 2'b00};
        cnt    <= CW'(LATENCY - 1);
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (capture) rdata    <= word;
      if (do_load) load_ptr <= load_ptr + 1'b1;
    end
  end

`ifdef IMEM_OPCODE_CHECK_EN
  logic illegal_q;

  always_ff @(posedge CLK) begin
    if (RESET)        illegal_q <= 1'b0;
    else if (capture) illegal_q <= (word[31:24] > 8'h05);
  end

  assign bus.ILLEGAL = illegal_q;
`else
  assign bus.ILLEGAL = 1'b0;
`endif

  assign bus.READDATA   = rdata;
  assign bus.BUSYWAIT   = busy;
  assign bus.LOAD_READY = load_ready;
  assign bus.LOAD_PTR   = load_ptr;
endmodule

// File: tb/tb_imem_fetch.sv
// tb/tb_imem_fetch.sv - scoreboard bench for imem_fetch: loader, fetch latency, contention, reset, opcode flag
module tb_imem_fetch;
  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
  localparam int AW    = 10;

  typedef struct {
    logic [31:0] word;
    logic        ill;
  } exp_t;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;

  imem_fetch_if #(.AW(AW)) bus();

  imem_fetch #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int         checks   = 0;
  int         failures = 0;
  int         exp_ptr  = 0;
  logic [7:0] m [DEPTH];
  exp_t       sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    int a;
    a = int'(addr[AW-1:2]) * 4;
    return {m[a+3], m[a+2], m[a+1], m[a]};
  endfunction

  function automatic logic model_ill(input logic [31:0] w);
`ifdef IMEM_OPCODE_CHECK_EN
    return w[31:24] > 8'h05;
`else
    return (w == 32'h0) && (w != 32'h0);
`endif
  endfunction

  task automatic push_exp(input logic [31:0] addr);
    exp_t e;
    e.word = model_word(addr);
    e.ill  = model_ill(e.word);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb_empty"}, 32'(sb.size() == 0), 32'd0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_readdata"}, bus.READDATA, e.word);
      check({tag, "_illegal"}, 32'(bus.ILLEGAL), 32'(e.ill));
    end
  endtask

  task automatic load_byte(input logic [7:0] b);
    bus.LOAD_VALID = 1'b1;
    bus.LOAD_BYTE  = b;
    #1;
    check("load_ready", 32'(bus.LOAD_READY), 32'd1);
    m[exp_ptr] = b;
    exp_ptr    = (exp_ptr + 1) % DEPTH;
    tick();
  endtask

  // Starts at a time just after a rising edge with the FSM idle; returns one cycle after DONE.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input logic [31:0] addr_in_wait);
    int stall;
    push_exp(addr);
    bus.READ    = 1'b1;
    bus.ADDRESS = addr;
    #1;
    check({tag, "_busy_t0"}, 32'(bus.BUSYWAIT), 32'd1);
    check({tag, "_ldrdy_t0"}, 32'(bus.LOAD_READY), 32'd0);
    tick();
    bus.READ    = 1'b0;
    bus.ADDRESS = addr_in_wait;
    stall = 1;
    while (bus.BUSYWAIT && stall < 20) begin
      tick();
      stall++;
    end
    check({tag, "_stall"}, 32'(stall), 32'(LAT + 1));
    check({tag, "_ldrdy_done"}, 32'(bus.LOAD_READY), 32'd0);
    pop_check(tag);
    tick();
  endtask

  initial begin
    int n;
    logic [7:0] prog [12];
    bus.READ       = 1'b0;
    bus.ADDRESS    = 32'h0;
    bus.LOAD_VALID = 1'b0;
    bus.LOAD_BYTE  = 8'h0;
    prog = '{8'h05, 8'h00, 8'h02, 8'h00, 8'h02, 8'h01, 8'h03, 8'h01,
             8'h00, 8'h00, 8'h00, 8'h06};

    repeat (3) tick();
    RESET = 1'b0;
    #1;
    check("rst_busy", 32'(bus.BUSYWAIT), 32'd0);
    check("rst_ldrdy", 32'(bus.LOAD_READY), 32'd1);
    check("rst_ptr", 32'(bus.LOAD_PTR), 32'd0);
    check("rst_readdata", bus.READDATA, 32'h0);
    check("rst_illegal", 32'(bus.ILLEGAL), 32'd0);
    bus.READ = 1'b1;
    #1;
    check("rst_busy_read", 32'(bus.BUSYWAIT), 32'd1);
    check("rst_ldrdy_read", 32'(bus.LOAD_READY), 32'd0);
    bus.READ = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      load_byte(prog[i]);
      if (i == 7) check("ptr_after8", 32'(bus.LOAD_PTR), 32'd8);
    end
    bus.LOAD_VALID = 1'b0;
    check("ptr_after12", 32'(bus.LOAD_PTR), 32'd12);

    do_fetch("f0", 32'h0, 32'h0);
    do_fetch("f4", 32'h4, 32'h4);
    do_fetch("wrap_mis", 32'h0000_0406, 32'h0);

    // Back-to-back with READ held: DONE-to-DONE spacing is LATENCY+2.
    push_exp(32'h4);
    push_exp(32'h4);
    bus.READ    = 1'b1;
    bus.ADDRESS = 32'h4;
    #1;
    n = 0;
    while (bus.BUSYWAIT && n < 20) begin
      tick();
      n++;
    end
    pop_check("b2b_first");
    tick();
    check("b2b_reaccept", 32'(bus.BUSYWAIT), 32'd1);
    n = 1;
    while (bus.BUSYWAIT && n < 20) begin
      tick();
      n++;
    end
    check("b2b_period", 32'(n), 32'(LAT + 2));
    bus.READ = 1'b0;
    pop_check("b2b_second");
    tick();

    // Contention: the pending loader byte waits out the whole fetch.
    bus.LOAD_VALID = 1'b1;
    bus.LOAD_BYTE  = 8'hAA;
    do_fetch("cont", 32'h0, 32'h0);
    check("cont_ptr_held", 32'(bus.LOAD_PTR), 32'd12);
    check("cont_ldrdy_idle", 32'(bus.LOAD_READY), 32'd1);
    m[exp_ptr] = 8'hAA;
    exp_ptr++;
    tick();
    bus.LOAD_VALID = 1'b0;
    check("cont_ptr_adv", 32'(bus.LOAD_PTR), 32'd13);

    // Reset during WAIT aborts the fetch without a DONE.
    bus.READ    = 1'b1;
    bus.ADDRESS = 32'h4;
    tick();
    bus.READ = 1'b0;
    RESET    = 1'b1;
    tick();
    RESET   = 1'b0;
    exp_ptr = 0;
    check("rmid_busy", 32'(bus.BUSYWAIT), 32'd0);
    check("rmid_readdata", bus.READDATA, 32'h0);
    check("rmid_ptr", 32'(bus.LOAD_PTR), 32'd0);
    n = 0;
    for (int i = 0; i < LAT + 2; i++) begin
      tick();
      if (bus.READDATA != 32'h0 || bus.BUSYWAIT) n++;
    end
    check("rmid_no_done", 32'(n), 32'd0);

    // Reset together with a loader byte: nothing is written.
    RESET          = 1'b1;
    bus.LOAD_VALID = 1'b1;
    bus.LOAD_BYTE  = 8'h55;
    tick();
    RESET          = 1'b0;
    bus.LOAD_VALID = 1'b0;
    check("rload_ptr", 32'(bus.LOAD_PTR), 32'd0);
    do_fetch("refetch0", 32'h0, 32'h0);

    do_fetch("ill_w8", 32'h8, 32'h8);
    tick();
    check("ill_hold", 32'(bus.ILLEGAL), 32'(model_ill(model_word(32'h8))));
    do_fetch("ill_w0", 32'h0, 32'h0);

    // Fill the whole array so LOAD_PTR wraps back to zero.
    for (int i = 0; i < DEPTH; i++) load_byte(8'(i));
    bus.LOAD_VALID = 1'b0;
    check("ptr_wrap", 32'(bus.LOAD_PTR), 32'd0);
    do_fetch("top_word", 32'h0000_03FC, 32'h0);
    do_fetch("hi_addr", 32'hFFFF_FFF9, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
